// File: rtl/fe_mult_responder_if.sv
// rtl/fe_mult_responder_if.sv - shared field-multiplier request/response port
//
// Purpose: bundles the handshake between a ge_* sequencer (master) and the
// field multiplier (slave).
// Signals:
//   mult_op_a  [319:0]  operand f, 10 signed 32-bit limbs, limb i at [32i+31:32i]
//   mult_op_b  [319:0]  operand g, same packing
//   mult_valid          request level, held with stable operands until mult_done
//   mult_res   [319:0]  product h, same packing
//   mult_done           one-cycle pulse marking mult_res valid
//   busy                responder is not idle
interface fe_mult_responder_if;
  logic [319:0] mult_op_a;
  logic [319:0] mult_op_b;
  logic         mult_valid;
  logic [319:0] mult_res;
  logic         mult_done;
  logic         busy;

  modport master (
    output mult_op_a, mult_op_b, mult_valid,
    input  mult_res, mult_done, busy
  );

  modport slave (
    input  mult_op_a, mult_op_b, mult_valid,
    output mult_res, mult_done, busy
  );
endinterface

// File: rtl/fe_mult_responder.sv
// rtl/fe_mult_responder.sv - iterative GF(2^255-19) multiplier, 10-limb radix 2^25.5
//
// Purpose: multiplies two field elements given as 10 signed limbs and returns
// the reduced product in carried limb form. Limb products are accumulated a few
// pairs per cycle, then a serial 12-step carry chain bounds the limbs.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   mult  slave side of fe_mult_responder_if (operands/valid in, result/done/busy out)
module fe_mult_responder #(
  parameter int MACS_PER_CYCLE = 1,
  parameter int ACC_W          = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  fe_mult_responder_if.slave        mult
);

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_CARRY, S_DONE, S_RELEASE} state_t;

  // Each MAC cycle covers MACS_PER_CYCLE consecutive j for one i, so the
  // k indices hit in one cycle are all distinct.
  localparam logic [3:0] J_LAST = 4'(10 - MACS_PER_CYCLE);
  localparam logic [3:0] J_STEP = 4'(MACS_PER_CYCLE);

  state_t                   state_q, state_d;
  logic [319:0]             f_q, f_d, g_q, g_d, res_q, res_d;
  logic signed [ACC_W-1:0]  h_q [10];
  logic signed [ACC_W-1:0]  h_d [10];
  logic [3:0]               i_q, i_d, j_q, j_d, step_q, step_d;

  logic [3:0]               ii, jj, kk, src, dst;
  logic [4:0]               ksum, shamt;
  logic signed [ACC_W-1:0]  term, half, rnd, c;

  function automatic logic signed [ACC_W-1:0] limb(input logic [319:0] v, input logic [3:0] idx);
    logic [31:0] raw;
    raw = v[32*idx +: 32];
    return {{(ACC_W-32){raw[31]}}, raw};
  endfunction

  function automatic logic signed [ACC_W-1:0] mul19(input logic signed [ACC_W-1:0] x);
    return (x <<< 4) + (x <<< 1) + x;
  endfunction

  // Source limb of each carry step; destination is the next limb (9 wraps to 0).
  function automatic logic [3:0] carry_src(input logic [3:0] s);
    logic [3:0] r;
    case (s)
      4'd1:    r = 4'd4;
      4'd2:    r = 4'd1;
      4'd3:    r = 4'd5;
      4'd4:    r = 4'd2;
      4'd5:    r = 4'd6;
      4'd6:    r = 4'd3;
      4'd7:    r = 4'd7;
      4'd8:    r = 4'd4;
      4'd9:    r = 4'd8;
      4'd10:   r = 4'd9;
      default: r = 4'd0;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    f_d     = f_q;
    g_d     = g_q;
    res_d   = res_q;
    i_d     = i_q;
    j_d     = j_q;
    step_d  = step_q;
    h_d     = h_q;
    ii      = '0;
    jj      = '0;
    kk      = '0;
    ksum    = '0;
    term    = '0;
    src     = '0;
    dst     = '0;
    shamt   = '0;
    half    = '0;
    rnd     = '0;
    c       = '0;

    case (state_q)
      S_IDLE: begin
        if (mult.mult_valid) begin
          f_d    = mult.mult_op_a;
          g_d    = mult.mult_op_b;
          h_d    = '{default: '0};
          i_d    = '0;
          j_d    = '0;
          step_d = '0;
          state_d = S_MAC;
        end
      end

      S_MAC: begin
        for (int m = 0; m < MACS_PER_CYCLE; m++) begin
          ii   = i_q;
          jj   = j_q + 4'(m);
          term = limb(f_q, ii) * limb(g_q, jj);
          // Odd*odd limbs carry an extra factor 2 from the 25.5-bit radix.
          if (ii[0] && jj[0]) term = term <<< 1;
          ksum = {1'b0, ii} + {1'b0, jj};
          // Wrap past 2^255 folds back as 19 since 2^255 = 19 mod p.
          if (ksum >= 5'd10) begin
            kk   = 4'(ksum - 5'd10);
            term = mul19(term);
          end else begin
            kk   = ksum[3:0];
          end
          h_d[kk] = h_d[kk] + term;
        end
        if (j_q == J_LAST) begin
          j_d = '0;
          if (i_q == 4'd9) state_d = S_CARRY;
          else             i_d = i_q + 4'd1;
        end else begin
          j_d = j_q + J_STEP;
        end
      end

      S_CARRY: begin
        src   = carry_src(step_q);
        dst   = (src == 4'd9) ? 4'd0 : src + 4'd1;
        shamt = src[0] ? 5'd25 : 5'd26;
        half[shamt - 5'd1] = 1'b1;
        rnd   = h_q[src] + half;
        c     = rnd >>> shamt;
        h_d[dst] = h_q[dst] + ((src == 4'd9) ? mul19(c) : c);
        h_d[src] = h_q[src] - (c <<< shamt);
        if (step_q == 4'd11) begin
          step_d  = '0;
          state_d = S_DONE;
          for (int n = 0; n < 10; n++) res_d[32*n +: 32] = h_d[n][31:0];
        end else begin
          step_d = step_q + 4'd1;
        end
      end

      S_DONE: state_d = S_RELEASE;

      S_RELEASE: begin
        if (!mult.mult_valid) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      f_q     <= '0;
      g_q     <= '0;
      res_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      step_q  <= '0;
      h_q     <= '{default: '0};
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      g_q     <= g_d;
      res_q   <= res_d;
      i_q     <= i_d;
      j_q     <= j_d;
      step_q  <= step_d;
      h_q     <= h_d;
    end
  end

  assign mult.mult_res  = res_q;
  assign mult.mult_done = (state_q == S_DONE);
  assign mult.busy      = (state_q != S_IDLE);

endmodule
